// File: rtl/lvds_pulse_conditioner_if.sv
// Bundle between the LVDS pulse source and the pulse conditioner.
// The master drives the raw pulse, the slave (conditioner) returns the conditioned results.
interface lvds_pulse_conditioner_if #(
    parameter int unsigned WIDTH_W = 16
);
    logic               signal;
    logic               detection;
    logic               level;
    logic               width_valid;
    logic [WIDTH_W-1:0] width;
    logic [15:0]        dropped_count;

    modport master (
        output signal,
        input  detection,
        input  level,
        input  width_valid,
        input  width,
        input  dropped_count
    );

    modport slave (
        input  signal,
        output detection,
        output level,
        output width_valid,
        output width,
        output dropped_count
    );
endinterface

// File: rtl/lvds_pulse_conditioner.sv
// Synchronises and glitch-filters the LVDS buffer output, strobes accepted rising edges
// under a re-trigger holdoff, and measures the filtered high time of each accepted pulse.
module lvds_pulse_conditioner #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned HOLDOFF     = 16,
    parameter int unsigned WIDTH_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    lvds_pulse_conditioner_if.slave   bus
);
    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam int unsigned HCW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_HIGH_ACC = 2'd1,
        ST_HIGH_REJ = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   level_q;
    logic                   level_d;
    logic [FCW-1:0]         filt_cnt_q;
    logic [FCW-1:0]         filt_cnt_d;

    state_t                 state_q;
    logic [WIDTH_W-1:0]     width_cnt_q;
    logic [WIDTH_W-1:0]     width_q;
    logic [HCW-1:0]         hold_q;
    logic                   det_q;
    logic                   width_valid_q;
    logic [15:0]            dropped_q;

    logic                   sync_out_s;
    logic                   toggle_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   hold_free_s;

    // Next-state of the synchroniser and glitch filter, plus the edge events they imply.
    always_comb begin
        sync_out_s = sync_q[SYNC_STAGES-1];
        sync_d     = {sync_q[SYNC_STAGES-2:0], bus.signal};
        toggle_s   = 1'b0;
        filt_cnt_d = {FCW{1'b0}};
        if (sync_out_s != level_q) begin
            if ((filt_cnt_q + FCW'(1)) == FCW'(FILTER_LEN)) begin
                toggle_s   = 1'b1;
                filt_cnt_d = {FCW{1'b0}};
            end else begin
                filt_cnt_d = filt_cnt_q + FCW'(1);
            end
        end else begin
            filt_cnt_d = {FCW{1'b0}};
        end
        level_d = toggle_s ? ~level_q : level_q;
        rise_s  = toggle_s & ~level_q;
        fall_s  = toggle_s & level_q;
        // A counter at 1 reaches zero on this very edge, so that rise is still accepted.
        hold_free_s = (hold_q <= HCW'(1));
    end

    // Synchroniser chain, filtered level and filter run-length counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= {SYNC_STAGES{1'b0}};
            level_q    <= 1'b0;
            filt_cnt_q <= {FCW{1'b0}};
        end else begin
            sync_q     <= sync_d;
            level_q    <= level_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    // Pulse FSM with holdoff, drop counting and width measurement; all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LOW;
            width_cnt_q   <= {WIDTH_W{1'b0}};
            width_q       <= {WIDTH_W{1'b0}};
            hold_q        <= {HCW{1'b0}};
            det_q         <= 1'b0;
            width_valid_q <= 1'b0;
            dropped_q     <= 16'h0000;
        end else begin
            det_q         <= 1'b0;
            width_valid_q <= 1'b0;
            if (hold_q != {HCW{1'b0}}) begin
                hold_q <= hold_q - HCW'(1);
            end else begin
                hold_q <= hold_q;
            end
            case (state_q)
                ST_LOW: begin
                    if (rise_s) begin
                        if (hold_free_s) begin
                            state_q     <= ST_HIGH_ACC;
                            det_q       <= 1'b1;
                            width_cnt_q <= WIDTH_W'(1);
                            hold_q      <= HCW'(HOLDOFF);
                        end else begin
                            state_q <= ST_HIGH_REJ;
                            if (dropped_q != 16'hFFFF) begin
                                dropped_q <= dropped_q + 16'd1;
                            end else begin
                                dropped_q <= dropped_q;
                            end
                        end
                    end else begin
                        state_q <= ST_LOW;
                    end
                end
                ST_HIGH_ACC: begin
                    if (fall_s) begin
                        state_q       <= ST_LOW;
                        width_q       <= width_cnt_q;
                        width_valid_q <= 1'b1;
                    end else if (width_cnt_q != {WIDTH_W{1'b1}}) begin
                        width_cnt_q <= width_cnt_q + WIDTH_W'(1);
                    end else begin
                        width_cnt_q <= width_cnt_q;
                    end
                end
                ST_HIGH_REJ: begin
                    if (fall_s) begin
                        state_q <= ST_LOW;
                    end else begin
                        state_q <= ST_HIGH_REJ;
                    end
                end
                default: begin
                    state_q <= ST_LOW;
                end
            endcase
        end
    end

    assign bus.detection     = det_q;
    assign bus.level         = level_q;
    assign bus.width_valid   = width_valid_q;
    assign bus.width         = width_q;
    assign bus.dropped_count = dropped_q;
endmodule

// File: tb/tb_lvds_pulse_conditioner.sv
// Randomised bench for lvds_pulse_conditioner: two configurations share one stimulus stream
// and are compared every cycle against an event-level reference model.
module tb_lvds_pulse_conditioner;
    localparam int NMAX = 20000;

    // Instance 0: defaults. Instance 1: deeper sync, short filter, short holdoff, 4-bit width.
    localparam int A_S = 2, A_F = 4, A_H = 16, A_W = 16;
    localparam int B_S = 3, B_F = 2, B_H = 5,  B_W = 4;

    logic clk;
    logic rst;

    lvds_pulse_conditioner_if #(.WIDTH_W(A_W)) bus_a ();
    lvds_pulse_conditioner_if #(.WIDTH_W(B_W)) bus_b ();

    lvds_pulse_conditioner #(
        .SYNC_STAGES(A_S), .FILTER_LEN(A_F), .HOLDOFF(A_H), .WIDTH_W(A_W)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    lvds_pulse_conditioner #(
        .SYNC_STAGES(B_S), .FILTER_LEN(B_F), .HOLDOFF(B_H), .WIDTH_W(B_W)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic samp [NMAX];
    int   edge_n        = 0;
    int   last_rst_edge = -1;
    int   p_s [2];
    int   p_f [2];
    int   p_h [2];
    int   p_wmax [2];
    logic m_lvl [2];
    logic m_acc [2];
    logic m_have_det [2];
    int   m_last_det [2];
    int   m_rise [2];
    logic m_det [2];
    logic m_wv [2];
    int   m_width [2];
    int   m_drop [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Raw input sampled at edge k, as seen after the most recent reset.
    function automatic logic s_at(input int k);
        if (k > last_rst_edge && k >= 0 && k < NMAX) return samp[k];
        return 1'b0;
    endfunction

    task automatic model_clear(input int i);
        m_lvl[i]      = 1'b0;
        m_acc[i]      = 1'b0;
        m_have_det[i] = 1'b0;
        m_last_det[i] = 0;
        m_rise[i]     = 0;
        m_det[i]      = 1'b0;
        m_wv[i]       = 1'b0;
        m_width[i]    = 0;
        m_drop[i]     = 0;
    endtask

    // Level flips once the synchronised input has differed from it on the last F edges.
    task automatic model_inst(input int i);
        int  n;
        logic all_diff;
        n        = edge_n;
        all_diff = 1'b1;
        for (int j = 0; j < p_f[i]; j++) begin
            if (s_at(n - p_s[i] - j) == m_lvl[i]) all_diff = 1'b0;
        end
        m_det[i] = 1'b0;
        m_wv[i]  = 1'b0;
        if (all_diff) begin
            if (!m_lvl[i]) begin
                m_lvl[i] = 1'b1;
                if (!m_have_det[i] || (n - m_last_det[i]) >= p_h[i]) begin
                    m_det[i]      = 1'b1;
                    m_acc[i]      = 1'b1;
                    m_have_det[i] = 1'b1;
                    m_last_det[i] = n;
                    m_rise[i]     = n;
                end else begin
                    m_acc[i]  = 1'b0;
                    m_drop[i] = (m_drop[i] < 65535) ? m_drop[i] + 1 : 65535;
                end
            end else begin
                m_lvl[i] = 1'b0;
                if (m_acc[i]) begin
                    m_wv[i]    = 1'b1;
                    m_width[i] = ((n - m_rise[i]) > p_wmax[i]) ? p_wmax[i] : (n - m_rise[i]);
                end
                m_acc[i] = 1'b0;
            end
        end
    endtask

    task automatic model_edge(input logic sig, input logic r);
        if (edge_n < NMAX) samp[edge_n] = sig;
        if (r) begin
            last_rst_edge = edge_n;
            model_clear(0);
            model_clear(1);
        end else begin
            model_inst(0);
            model_inst(1);
        end
        edge_n++;
    endtask

    // One clock: drive at the falling edge, model at the rising edge, compare at the next fall.
    task automatic cycle(input logic sig, input logic r);
        bus_a.signal = sig;
        bus_b.signal = sig;
        rst          = r;
        @(posedge clk);
        model_edge(sig, r);
        @(negedge clk);
        chk("a_detection",   {31'd0, bus_a.detection},   {31'd0, m_det[0]});
        chk("a_level",       {31'd0, bus_a.level},       {31'd0, m_lvl[0]});
        chk("a_width_valid", {31'd0, bus_a.width_valid}, {31'd0, m_wv[0]});
        chk("a_width",       {16'd0, bus_a.width},       m_width[0]);
        chk("a_dropped",     {16'd0, bus_a.dropped_count}, m_drop[0]);
        chk("b_detection",   {31'd0, bus_b.detection},   {31'd0, m_det[1]});
        chk("b_level",       {31'd0, bus_b.level},       {31'd0, m_lvl[1]});
        chk("b_width_valid", {31'd0, bus_b.width_valid}, {31'd0, m_wv[1]});
        chk("b_width",       {28'd0, bus_b.width},       m_width[1]);
        chk("b_dropped",     {16'd0, bus_b.dropped_count}, m_drop[1]);
    endtask

    task automatic run(input logic sig, input int len);
        for (int k = 0; k < len; k++) cycle(sig, 1'b0);
    endtask

    initial begin
        logic v;
        int   len;
        p_s[0] = A_S; p_f[0] = A_F; p_h[0] = A_H; p_wmax[0] = (1 << A_W) - 1;
        p_s[1] = B_S; p_f[1] = B_F; p_h[1] = B_H; p_wmax[1] = (1 << B_W) - 1;
        model_clear(0);
        model_clear(1);
        rst          = 1'b1;
        bus_a.signal = 1'b0;
        bus_b.signal = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1);
        run(1'b0, 5);

        // Clean 20-cycle pulse
        run(1'b1, 20); run(1'b0, 30);
        // Short glitch
        run(1'b1, 3);  run(1'b0, 20);
        // Rises at t, t+10, t+26
        run(1'b1, 5); run(1'b0, 5); run(1'b1, 5); run(1'b0, 11); run(1'b1, 5); run(1'b0, 30);
        // Long pulse saturates the narrow width counter
        run(1'b1, 40); run(1'b0, 30);
        // Reset on the 10th high sample of a 30-sample pulse
        run(1'b1, 9); cycle(1'b1, 1'b1); run(1'b1, 20); run(1'b0, 30);
        // Holdoff boundary: 16 apart, then 15 apart
        run(1'b1, 5); run(1'b0, 11); run(1'b1, 5); run(1'b0, 30);
        run(1'b1, 5); run(1'b0, 10); run(1'b1, 5); run(1'b0, 30);

        // Random segments with glitches and occasional reset
        v = 1'b0;
        for (int seg = 0; seg < 350; seg++) begin
            if ($urandom_range(0, 39) == 0) begin
                cycle(1'($urandom_range(0, 1)), 1'b1);
            end
            v   = ~v;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 25);
            run(v, len);
        end
        run(1'b0, 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
